// File: rtl/dmem_arbiter_pkg.sv
// mem_arb_pkg: shared response-owner encoding and default sizes for the data-RAM arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_WAIT_DEF = 4;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } own_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, video and RAM signals; slave is the arbiter side, master the environment
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  modport slave (
    input  cpu_req, cpu_wren, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_rdata,
    output cpu_rdata, cpu_stall, vid_gnt, vid_rvalid, vid_rdata, ram_wen, ram_addr, ram_wdata
  );
  modport master (
    output cpu_req, cpu_wren, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_rdata,
    input  cpu_rdata, cpu_stall, vid_gnt, vid_rvalid, vid_rdata, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dmem_arbiter_starve.sv
// arb_starve_counter: counts denied video cycles and raises force_gnt once MAX_WAIT is reached
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic vid_req,
  input  logic vid_gnt,
  output logic force_gnt
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WAIT);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    force_gnt = vid_req && (cnt_q == MAX_C);
    cnt_d = (!vid_req || vid_gnt) ? '0 : (cnt_q == MAX_C) ? MAX_C : cnt_q + 1'b1;
  end
  always_ff @(posedge clock)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU and the video reader, CPU first
module dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input logic           clock,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  logic              force_gnt, cpu_gnt;
  own_e              owner_q, owner_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  arb_starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clock    (clock),
    .reset    (reset),
    .vid_req  (bus.vid_req),
    .vid_gnt  (bus.vid_gnt),
    .force_gnt(force_gnt)
  );
  // every output is held at zero while reset is asserted, including a response still in flight
  always_comb begin
    cpu_gnt        = !reset && bus.cpu_req && !force_gnt;
    bus.vid_gnt    = !reset && bus.vid_req && (force_gnt || !bus.cpu_req);
    bus.cpu_stall  = !reset && bus.cpu_req && force_gnt;
    bus.ram_wen    = cpu_gnt && bus.cpu_wren;
    bus.ram_addr   = cpu_gnt ? bus.cpu_addr : bus.vid_gnt ? bus.vid_addr : '0;
    bus.ram_wdata  = cpu_gnt ? bus.cpu_wdata : '0;
    owner_d        = reset ? OWN_NONE : bus.vid_gnt ? OWN_VID
                   : (cpu_gnt && !bus.cpu_wren) ? OWN_CPU : OWN_NONE;
    bus.vid_rvalid = !reset && (owner_q == OWN_VID);
    bus.vid_rdata  = bus.vid_rvalid ? bus.ram_rdata : '0;
    bus.cpu_rdata  = reset ? '0 : (owner_q == OWN_CPU) ? bus.ram_rdata : cpu_rdata_q;
    cpu_rdata_d    = bus.cpu_rdata;
  end
  always_ff @(posedge clock)
    if (reset) begin
      owner_q     <= OWN_NONE;
      cpu_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
endmodule
